// File: rtl/dmem_port_arbiter.sv
// DMEM port arbiter: shares BRAM port B between the MEM-stage LSU (CPU) and
// an external loader/debug requester (LDR). The CPU has priority; a starvation
// counter forces an occasional loader grant, and a lock mode gives the loader
// exclusive ownership while the pipeline is held.
module dmem_port_arbiter #(
    parameter int STARVE_LIM = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_lock,
    input  logic [3:0]        ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_ready,
    output logic [31:0]       ldr_rdata,
    output logic              ldr_rvalid,
    output logic              ldr_locked,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FORCE = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM - 1);

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic       locked_q;
    logic       cpu_gnt_s;
    logic       ldr_gnt_s;
    logic       ldr_refused_s;

    // Per-cycle grant decision from the current state and the live requests.
    always_comb begin
        cpu_gnt_s = 1'b0;
        ldr_gnt_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cpu_req) begin
                    cpu_gnt_s = 1'b1;
                end else if (ldr_req) begin
                    ldr_gnt_s = 1'b1;
                end else begin
                    cpu_gnt_s = 1'b0;
                end
            end
            ST_FORCE: ldr_gnt_s = ldr_req;
            ST_LOCK:  ldr_gnt_s = ldr_req;
            default: begin
                cpu_gnt_s = 1'b0;
                ldr_gnt_s = 1'b0;
            end
        endcase
    end

    assign ldr_refused_s = ldr_req & ~ldr_gnt_s;

    // Next state, starvation count and read-owner computation.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            ST_RUN: begin
                if (ldr_gnt_s) begin
                    starve_d = 4'd0;
                end else if (ldr_refused_s) begin
                    starve_d = starve_q + 4'd1;
                end else begin
                    starve_d = starve_q;
                end
                // Lock outranks the forced grant when both become due together.
                if (ldr_lock) begin
                    state_d = ST_LOCK;
                end else if (ldr_refused_s && (starve_q == STARVE_MAX)) begin
                    state_d = ST_FORCE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FORCE: begin
                starve_d = 4'd0;
                state_d  = ldr_lock ? ST_LOCK : ST_RUN;
            end
            ST_LOCK: begin
                starve_d = 4'd0;
                state_d  = ldr_lock ? ST_LOCK : ST_RUN;
            end
            default: begin
                starve_d = 4'd0;
                state_d  = ST_RUN;
            end
        endcase

        if (cpu_gnt_s && (cpu_we == 4'd0)) begin
            owner_d = OWN_CPU;
        end else if (ldr_gnt_s && (ldr_we == 4'd0)) begin
            owner_d = OWN_LDR;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // State, counter, read-owner and lock-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            starve_q <= 4'd0;
            owner_q  <= OWN_NONE;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            locked_q <= (state_d == ST_LOCK);
        end
    end

    // Port B mux: drive the granted requester, otherwise an idle all-zero bus.
    always_comb begin
        mem_we    = 4'd0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (cpu_gnt_s) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ldr_gnt_s) begin
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end else begin
            mem_we    = 4'd0;
            mem_addr  = '0;
            mem_wdata = 32'd0;
        end
    end

    // locked_q mirrors state_q == ST_LOCK, so it doubles as the hold for the CPU.
    assign cpu_stall  = locked_q | (cpu_req & ~cpu_gnt_s);
    assign ldr_ready  = ldr_gnt_s;
    assign ldr_locked = locked_q;
    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign ldr_rvalid = (owner_q == OWN_LDR);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
    assign ldr_rdata  = ldr_rvalid ? mem_rdata : 32'd0;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares BRAM port B (the DMEM port) between the pipeline MEM stage (CPU) and an external loader/debug requester (LDR).
- CPU normally has priority. A starvation counter guarantees the loader progress, and a lock mode gives the loader exclusive ownership while the CPU is held.
- Sits between the MEM-stage LSU outputs and BRAM port B. Drives the stall that freezes the pipeline registers.

Parameters:
- STARVE_LIM, 4: consecutive cycles the loader may be refused before it is forced a grant; legal range 1..15.
- ADDR_W, 32: address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cpu_req  input  1  MEM stage needs the port this cycle (MemRead|MemWrite)
- cpu_we  input  4  byte write enables from LSU
- cpu_addr  input  ADDR_W  byte address from LSU
- cpu_wdata  input  32  write data from LSU
- cpu_rdata  output  32  read data, valid when cpu_rvalid
- cpu_rvalid  output  1  CPU read data returned this cycle
- cpu_stall  output  1  freeze PC/IF_ID/ID_EX/EX_MEM and bubble MEM_WB
- ldr_req  input  1  loader transaction valid
- ldr_lock  input  1  loader requests exclusive ownership
- ldr_we  input  4  loader byte write enables (0 = read)
- ldr_addr  input  ADDR_W  loader byte address
- ldr_wdata  input  32  loader write data
- ldr_ready  output  1  loader transaction accepted this cycle (req&ready = transfer)
- ldr_rdata  output  32  loader read data, valid when ldr_rvalid
- ldr_rvalid  output  1  loader read data returned this cycle
- ldr_locked  output  1  LOCK state active
- mem_we  output  4  to BRAM web
- mem_addr  output  ADDR_W  to BRAM addrb
- mem_wdata  output  32  to BRAM dib
- mem_rdata  input  32  from BRAM dob; valid 1 cycle after address

Behaviour:
- States: RUN, FORCE, LOCK. Reset -> RUN.
- Reset values: starve_cnt=0, rd_owner=none, cpu_rvalid=0, ldr_rvalid=0, ldr_locked=0.
- Grant is combinational per cycle from the current state and inputs. mem_* are muxed from the granted requester. With no grant, mem_we=0, mem_addr=0, mem_wdata=0.
- RUN:
  - cpu_req=1: grant CPU.
  - else ldr_req=1: grant LDR.
  - While ldr_req=1 and refused, starve_cnt increments; any loader grant clears it.
  - If ldr_lock=1 -> LOCK next cycle. Takes precedence over FORCE.
  - Else if starve_cnt reaches STARVE_LIM-1 while refused -> FORCE next cycle.
- FORCE:
  - Grant LDR if ldr_req=1, else nobody. cpu_stall=cpu_req.
  - Clear starve_cnt.
  - -> RUN next cycle, or -> LOCK if ldr_lock=1. Lasts exactly one cycle.
- LOCK:
  - ldr_locked=1 and cpu_stall=1 unconditionally, including while cpu_req=0.
  - Grant LDR whenever ldr_req=1.
  - ldr_lock=0 -> RUN next cycle. A loader grant is still allowed in the exit cycle.
- Outputs in all states:
  - cpu_stall = cpu_req & ~cpu_grant, except in LOCK.
  - ldr_ready = loader grant.
- Read return:
  - rd_owner is registered as {CPU, LDR, none} for any granted transaction with we=0.
  - Next cycle, the matching *_rvalid=1, and *_rdata=mem_rdata.
  - Writes produce no rvalid.
  - A stalled CPU is never granted, so a CPU read returns exactly 1 cycle after its un-stalled grant.
- Simultaneous events:
  - cpu_req & ldr_req in RUN with starve_cnt<STARVE_LIM-1: CPU wins.
  - Write then read of the same address on consecutive cycles is ordered by BRAM. The arbiter adds no bypass.
- Reset mid-operation: a pending rvalid is dropped, the state returns to RUN, and the counter clears on the same edge.

Test Plan:
- Reset, then cpu_req=1, cpu_we=0, cpu_addr=0x40, with memory[0x40]=0xDEADBEEF -> mem_addr=0x40 the same cycle; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF the next cycle; cpu_stall=0 throughout.
- Continuous cpu_req=1 and ldr_req=1, STARVE_LIM=4:
  - cycles 0-3: CPU granted.
  - cycle 4: FORCE, ldr_ready=1 and cpu_stall=1.
  - cycle 5: CPU granted again; the pattern repeats with period 5.
- Only ldr_req=1, ldr_we=0xF, ldr_addr=0x100, ldr_wdata=0x12345678 -> ldr_ready=1 and mem_we=0xF. A following loader read of 0x100 -> ldr_rvalid=1 and ldr_rdata=0x12345678 one cycle later.
- Assert ldr_lock=1 with cpu_req=1:
  - cpu_stall=1 from the next cycle, ldr_locked=1, and 8 back-to-back loader writes accepted at 1 per cycle.
  - Drop ldr_lock: the CPU is granted the cycle after.
- Assert rst during LOCK with a loader read in flight -> the next cycle has ldr_rvalid=0, ldr_locked=0, cpu_stall=cpu_req & 0 (CPU granted).
- ldr_lock=1 and starve_cnt=STARVE_LIM-1 in the same cycle -> the next state is LOCK, not FORCE.
